// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch/sequencing unit: sequencer FSM states,
//   decoder mode encodings, the NOP instruction word and the bit positions
//   inside the compare-flag vector.
package fetch_sequencer_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } seq_state_t;

  // Decoder mode encodings carried on NextState / CurrState.
  localparam logic [1:0] MODE_REG    = 2'b00;
  localparam logic [1:0] MODE_TARGET = 2'b01;
  localparam logic [1:0] MODE_IMM    = 2'b10;
  localparam logic [1:0] MODE_NOP    = 2'b11;

  // Instruction word presented to the decoder whenever the program is not running.
  localparam logic [8:0] NOP_INSTR = 9'h000;

  // Compare-flag layout: {zero, equal, gt}.
  localparam int CMP_W     = 3;
  localparam int CMP_ZERO  = 2;
  localparam int CMP_EQUAL = 1;
  localparam int CMP_GT    = 0;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// fetch_sequencer_pc_reg
//   Program counter register with start-load, branch-load, increment and hold.
//   The counter never wraps: an increment requested while at the top of the
//   address space is ignored, and at_top tells the owner that the next
//   sequential fetch would overrun the ROM.
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   synchronous active-low reset (loads START_ADDR)
//   load_start   in   load START_ADDR (highest priority after reset)
//   load_branch  in   load branch_addr
//   branch_addr  in   absolute branch destination
//   incr         in   advance by one (ignored at top of ROM)
//   pc           out  current program counter
//   at_top       out  pc is all ones
module fetch_sequencer_pc_reg #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_start,
  input  logic            load_branch,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            incr,
  output logic [PC_W-1:0] pc,
  output logic            at_top
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;

  assign at_top = &pc_reg;
  assign pc     = pc_reg;

  always_comb begin
    pc_next = pc_reg;
    if (load_start) begin
      pc_next = START_PC;
    end else if (load_branch) begin
      pc_next = branch_addr;
    end else if (incr && !at_top) begin
      pc_next = pc_reg + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg <= START_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch/sequencing unit between a combinational instruction ROM and the
//   control decoder. Owns the program counter, the decoder mode register,
//   the previous-instruction register and the compare-flag register, and
//   gates instruction delivery around a Start/Done handshake.
// Ports:
//   Clk               in   clock, rising edge
//   Reset             in   synchronous active-low reset
//   Start             in   (re)launch request, honoured in IDLE/HALT only
//   InstrIn           in   ROM word at ProgCtr
//   NextState         in   decoder next mode
//   PrevInstructionIn in   decoder's copy of the current instruction
//   CMPBitsIn         in   new compare flags {zero, equal, gt}
//   CMPLoadEn         in   capture CMPBitsIn
//   BranchEn          in   take branch this cycle
//   BranchTarget      in   absolute branch target (zero-extended)
//   Ack               in   decoder end-of-program flag
//   ProgCtr           out  ROM address
//   Instruction       out  InstrIn while running, NOP otherwise
//   CurrState         out  registered decoder mode
//   PrevInstruction   out  registered previous instruction
//   CMPBits           out  registered compare flags
//   Running           out  in RUN
//   Done              out  in HALT
//   Fault             out  sticky PC overrun flag
//   CycleCount        out  saturating count of RUN cycles
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int INSTR_W    = 9,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic [1:0]         NextState,
  input  logic [INSTR_W-1:0] PrevInstructionIn,
  input  logic [CMP_W-1:0]   CMPBitsIn,
  input  logic               CMPLoadEn,
  input  logic               BranchEn,
  input  logic [8:0]         BranchTarget,
  input  logic               Ack,
  output logic [PC_W-1:0]    ProgCtr,
  output logic [INSTR_W-1:0] Instruction,
  output logic [1:0]         CurrState,
  output logic [INSTR_W-1:0] PrevInstruction,
  output logic [CMP_W-1:0]   CMPBits,
  output logic               Running,
  output logic               Done,
  output logic               Fault,
  output logic [CNT_W-1:0]   CycleCount
);

  seq_state_t         state_reg, state_next;
  logic [1:0]         mode_reg, mode_next;
  logic [INSTR_W-1:0] prev_reg, prev_next;
  logic [CMP_W-1:0]   cmp_reg, cmp_next;
  logic               fault_reg, fault_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               pc_load_start;
  logic               pc_load_branch;
  logic               pc_incr;
  logic               pc_at_top;

  fetch_sequencer_pc_reg #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk         (Clk),
    .reset_n     (Reset),
    .load_start  (pc_load_start),
    .load_branch (pc_load_branch),
    .branch_addr (PC_W'(BranchTarget)),
    .incr        (pc_incr),
    .pc          (ProgCtr),
    .at_top      (pc_at_top)
  );

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    prev_next      = prev_reg;
    cmp_next       = cmp_reg;
    fault_next     = fault_reg;
    cnt_next       = cnt_reg;
    pc_load_start  = 1'b0;
    pc_load_branch = 1'b0;
    pc_incr        = 1'b0;

    case (state_reg)
      IDLE, HALT: begin
        if (Start) begin
          state_next    = RUN;
          pc_load_start = 1'b1;
          mode_next     = MODE_REG;
          prev_next     = INSTR_W'(NOP_INSTR);
          cmp_next      = '0;
          cnt_next      = '0;
          fault_next    = 1'b0;
        end
      end

      RUN: begin
        // Every RUN cycle is counted, the Ack cycle included.
        if (!(&cnt_reg)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // Flags are captured on the Ack cycle too, so the final compare
        // result of the program survives into HALT.
        if (CMPLoadEn) begin
          cmp_next = CMPBitsIn;
        end
        if (Ack) begin
          // End of program beats a simultaneous branch; PC freezes.
          state_next = HALT;
          mode_next  = MODE_REG;
        end else begin
          mode_next = NextState;
          prev_next = PrevInstructionIn;
          if (BranchEn) begin
            pc_load_branch = 1'b1;
          end else if (pc_at_top) begin
            // Sequential fetch past the last ROM word: stop rather than wrap.
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            pc_incr = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_REG;
      prev_reg  <= '0;
      cmp_reg   <= '0;
      fault_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      prev_reg  <= prev_next;
      cmp_reg   <= cmp_next;
      fault_reg <= fault_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Instruction     = (state_reg == RUN) ? InstrIn : INSTR_W'(NOP_INSTR);
  assign CurrState       = mode_reg;
  assign PrevInstruction = prev_reg;
  assign CMPBits         = cmp_reg;
  assign Running         = (state_reg == RUN);
  assign Done            = (state_reg == HALT);
  assign Fault           = fault_reg;
  assign CycleCount      = cnt_reg;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequential fetch/sequencing unit that consumes the control decoder's outputs and produces the decoder's inputs.
- Owns the program counter, decoder mode register (CurrState), previous-instruction register and compare-flag register.
- Gates instruction delivery around a Start/Done handshake with the testbench.
- Sits between the combinational instruction ROM (addressed by ProgCtr) and the control decoder.

Parameters:
- PC_W, 10, program counter width; ROM depth is 2^PC_W.
- INSTR_W, 9, instruction width.
- START_ADDR, 0, PC value loaded on Start.
- CNT_W, 16, cycle counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  level request to (re)launch program; honoured in IDLE/HALT only.
- InstrIn  in  INSTR_W  ROM data at ProgCtr (combinational ROM).
- NextState  in  2  decoder next mode (00 regular, 01 target, 10 immediate, 11 nop).
- PrevInstructionIn  in  INSTR_W  decoder's copy of current instruction.
- CMPBitsIn  in  3  new compare flags {zero, equal, gt}.
- CMPLoadEn  in  1  capture CMPBitsIn.
- BranchEn  in  1  take branch this cycle.
- BranchTarget  in  9  absolute branch target, zero-extended to PC_W.
- Ack  in  1  decoder end-of-program flag.
- ProgCtr  out  PC_W  ROM address.
- Instruction  out  INSTR_W  instruction to decoder: InstrIn in RUN, 9'h000 (NOP) otherwise.
- CurrState  out  2  registered decoder mode.
- PrevInstruction  out  INSTR_W  registered previous instruction.
- CMPBits  out  3  registered compare flags.
- Running  out  1  high in RUN.
- Done  out  1  high in HALT (normal end).
- Fault  out  1  sticky; PC overran top of ROM.
- CycleCount  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- FSM states: IDLE, RUN, HALT. Encoding lives in the shared package.
- Reset (Reset==0 at edge):
  - state=IDLE, ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0, CMPBits=000, Fault=0, CycleCount=0.
  - Running=0, Done=0.
  - Reset mid-RUN aborts immediately; no further register updates that cycle.
- IDLE/HALT:
  - Instruction forced to 0 (NOP).
  - If Start=1: next state RUN, ProgCtr<=START_ADDR, CurrState<=00, PrevInstruction<=0, CMPBits<=000, CycleCount<=0, Fault<=0.
  - Otherwise all registers hold.
  - First RUN cycle presents ROM[START_ADDR]; latency Start to first real instruction = 1 cycle.
- RUN, every cycle, in priority order:
  1. Ack=1: next state HALT, ProgCtr holds, CurrState<=00; CMPBits updates per CMPLoadEn. Ack beats BranchEn when both are asserted.
  2. BranchEn=1: ProgCtr<={0,BranchTarget}.
  3. Else ProgCtr<=ProgCtr+1. If ProgCtr==2^PC_W-1: Fault<=1, next state HALT, ProgCtr holds (no wrap).
- Also in every RUN cycle without Ack:
  - CurrState<=NextState.
  - PrevInstruction<=PrevInstructionIn.
  - CMPBits<=CMPBitsIn if CMPLoadEn, else hold.
- Start is ignored in RUN.
- CycleCount increments once per RUN cycle, including the Ack cycle, and saturates at all-ones.
- Multi-word instructions (target/immediate modes): the operand word advances PC like any other; the sequencer does not interpret opcodes.
- CurrState==11 is passed through unchanged; PC still increments.
- Done and Running are registered-state decodes, not combinational on Ack. Done rises the cycle after Ack.

Decomposition:
- Shared package (Definitions) holds:
  - seq_state_t enum {IDLE, RUN, HALT};
  - decoder mode constants MODE_REG=00, MODE_TARGET=01, MODE_IMM=10, MODE_NOP=11;
  - NOP_INSTR=9'h000;
  - CMP bit index constants.
- One sub-module is natural: pc_reg (PC register with load/increment/hold and an overflow detect output).
- The FSM, mode register and flag registers stay in fetch_sequencer.

Test Plan:
- Reset low 2 cycles, then Start=1 for 1 cycle with ROM[0..3] linear and no branches -> ProgCtr goes 0,1,2,3; Running=1 from cycle after Start; Instruction equals ROM word each cycle.
- BranchEn=1 with BranchTarget=9'h0A5 at PC=3 -> next ProgCtr=10'h0A5; CurrState takes NextState=01 the same edge.
- Ack=1 and BranchEn=1 at PC=7 -> HALT; ProgCtr stays 7; Done=1 next cycle; Instruction=0; CycleCount=8.
- CMPLoadEn=1 with CMPBitsIn=3'b011, then CMPLoadEn=0 with CMPBitsIn=3'b100 -> CMPBits=011 and holds.
- Force PC to 1023 with no branch -> Fault=1, HALT, ProgCtr=1023; a following Start clears Fault and PC=0.
- Reset=0 asserted mid-RUN at PC=5 -> next cycle IDLE, ProgCtr=0, all flags 0; Start asserted during RUN ignored (PC sequence unaffected).
